dbg_run_ctrl: RTL and testbench

DBG_RUN_CTRL -- requirements
Module: dbg_run_ctrl

---
 rtl/dbg_pkg.sv | 23 ++
 rtl/dbg_run_ctrl_debounce.sv | 53 +++++
 rtl/dbg_run_ctrl.sv | 101 ++++++++++
 tb/tb_dbg_run_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared types and widths for the debug run-control block.
package dbg_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DISP_W    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEB_W     = 16;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_TRAP = 2'd3
    } dbg_state_e;

    // Display capture: byte read back together with the address it came from.
    typedef struct packed {
        logic [REG_IDX_W-1:0] addr;
        logic [DISP_W-1:0]    data;
    } disp_cap_t;

endpackage

// File: rtl/dbg_run_ctrl_debounce.sv
// Step-button conditioning: 2-flop synchronizer, stability-window debouncer
// and a single-cycle pulse on the debounced rising edge.
module btn_debounce
    import dbg_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;

    // Counter runs only while the synced level disagrees with the stable level.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        pulse_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == DEB_CYCLES - DEB_W'(1)) begin
                stable_d = sync_q[1];
                pulse_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run/halt/single-step controller for the datapath, with instruction
// counter and a register-file byte display path.
module dbg_run_ctrl
    import dbg_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 btn_step,
    input  logic                 sw_run,
    input  logic [REG_IDX_W-1:0] sw_sel,
    input  logic                 trap_in,
    input  logic [DATA_W-1:0]    dbg_rdata,
    output logic                 core_en,
    output logic [REG_IDX_W-1:0] dbg_raddr,
    output logic [DISP_W-1:0]    disp_data,
    output logic                 disp_valid,
    output logic [1:0]           state_o,
    output logic [CNT_W-1:0]     instr_cnt
);

    logic [1:0]           run_sync_q;
    logic                 run_sync;
    logic                 step_pulse;
    dbg_state_e           state_q;
    dbg_state_e           state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [REG_IDX_W-1:0] raddr_q;
    disp_cap_t            cap_q;
    logic                 cap_vld_q;
    logic                 unused_rdata_hi;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_deb (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_step),
        .pulse_o (step_pulse)
    );

    assign run_sync = run_sync_q[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (run_sync)        state_d = ST_RUN;
                else if (step_pulse) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (trap_in)        state_d = ST_TRAP;
                else if (!run_sync) state_d = ST_HALT;
            end
            // A further step_pulse here is deliberately not looked at.
            ST_STEP: begin
                if (trap_in)   state_d = ST_TRAP;
                else if (tick) state_d = ST_HALT;
            end
            ST_TRAP: begin
                if (step_pulse && !run_sync) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Gated by reset so an in-flight tick cannot leak a step during reset.
    assign core_en = reset & tick & ((state_q == ST_RUN) | (state_q == ST_STEP));

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_sync_q <= '0;
            state_q    <= ST_HALT;
            cnt_q      <= '0;
            raddr_q    <= '0;
            cap_q      <= '0;
            cap_vld_q  <= 1'b0;
        end else begin
            run_sync_q <= {run_sync_q[0], sw_run};
            state_q    <= state_d;
            if (core_en) cnt_q <= cnt_q + CNT_W'(1);
            raddr_q    <= sw_sel;
            cap_q.addr <= raddr_q;
            cap_q.data <= dbg_rdata[DISP_W-1:0];
            cap_vld_q  <= 1'b1;
        end
    end

    // Valid only once the capture, the read address and the switches all agree.
    assign disp_valid = cap_vld_q && (cap_q.addr == raddr_q) && (raddr_q == sw_sel);
    assign disp_data  = disp_valid ? cap_q.data : '1;

    assign unused_rdata_hi = ^dbg_rdata[DATA_W-1:DISP_W];

    assign dbg_raddr = raddr_q;
    assign state_o   = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed scoreboard bench for dbg_run_ctrl with a short debounce window.
module tb_dbg_run_ctrl;

    localparam int DEB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        btn_step = 1'b0;
    logic        sw_run = 1'b0;
    logic [4:0]  sw_sel = 5'd0;
    logic        trap_in = 1'b0;
    logic [31:0] dbg_rdata;
    logic        core_en;
    logic [4:0]  dbg_raddr;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic [1:0]  state_o;
    logic [15:0] instr_cnt;

    logic [31:0] rf [32];

    dbg_run_ctrl #(
        .DEB_CYCLES (16'(DEB))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn_step   (btn_step),
        .sw_run     (sw_run),
        .sw_sel     (sw_sel),
        .trap_in    (trap_in),
        .dbg_rdata  (dbg_rdata),
        .core_en    (core_en),
        .dbg_raddr  (dbg_raddr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .state_o    (state_o),
        .instr_cnt  (instr_cnt)
    );

    assign dbg_rdata = rf[dbg_raddr];

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ce_seen = 0;
    int step_seen = 0;

    always @(negedge clk) begin
        if (core_en === 1'b1) ce_seen++;
        if (state_o === 2'd2) step_seen++;
    end

    string       tag_q[$];
    logic [31:0] val_q[$];

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_tests++;
        if (val_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
            return;
        end
        t = tag_q.pop_front();
        e = val_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push(tag, e);
        pop_check(obs);
    endtask

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ce;
        int base_step;
        int k;
        logic [15:0] exp_cnt;

        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        rf[3] = 32'h0000_0011;
        rf[7] = 32'h0000_00A5;
        exp_cnt = 16'd0;

        // Reset state
        tk(3);
        mid();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        chk("rst_raddr", 32'(dbg_raddr), 32'd0);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_disp_data", 32'(disp_data), 32'hFF);
        tk(1);
        reset = 1'b1;
        tk(2);
        mid();
        chk("post_rst_disp_valid", 32'(disp_valid), 32'd1);
        chk("post_rst_disp_data", 32'(disp_data), 32'h00);

        // Free run with a tick every 4 cycles
        tk(1);
        sw_run = 1'b1;
        tk(3);
        mid();
        chk("enter_run", 32'(state_o), 32'd1);
        tk(1);
        base_ce = ce_seen;
        for (int i = 0; i < 40; i++) begin
            tick = (i % 4 == 0);
            push("run_core_en", 32'(tick));
            if (i % 4 == 0) exp_cnt = exp_cnt + 16'd1;
            mid();
            pop_check(32'(core_en));
            tk(1);
        end
        tick = 1'b0;
        mid();
        chk("run_cnt", 32'(instr_cnt), 32'(exp_cnt));
        chk("run_cnt_10", 32'(instr_cnt), 32'd10);
        chk("run_ce_pulses", 32'(ce_seen - base_ce), 32'd10);
        chk("still_run", 32'(state_o), 32'd1);

        // Trap arrives in the same cycle the run switch drops
        tk(1);
        sw_run  = 1'b0;
        trap_in = 1'b1;
        tk(1);
        trap_in = 1'b0;
        mid();
        chk("trap_entry", 32'(state_o), 32'd3);
        tk(4);
        mid();
        chk("trap_holds", 32'(state_o), 32'd3);
        tk(1);
        btn_step = 1'b1;
        tk(DEB + 5);
        mid();
        chk("trap_to_halt", 32'(state_o), 32'd0);
        chk("trap_cnt", 32'(instr_cnt), 32'(exp_cnt));
        tk(1);
        btn_step = 1'b0;
        tk(DEB + 5);

        // Clean single step with ticks running
        base_ce   = ce_seen;
        base_step = step_seen;
        btn_step  = 1'b1;
        for (int i = 0; i < DEB + 5; i++) begin
            tick = (i % 4 == 0);
            tk(1);
        end
        btn_step = 1'b0;
        for (int i = 0; i < DEB + 10; i++) begin
            tick = (i % 4 == 0);
            tk(1);
        end
        tick = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        tk(1);
        mid();
        chk("step_seen", 32'(step_seen != base_step), 32'd1);
        chk("step_one_ce", 32'(ce_seen - base_ce), 32'd1);
        chk("step_cnt", 32'(instr_cnt), 32'(exp_cnt));
        chk("step_back_halt", 32'(state_o), 32'd0);

        // Bouncing button never settles long enough
        tk(1);
        base_ce   = ce_seen;
        base_step = step_seen;
        for (int i = 0; i < 48; i++) begin
            btn_step = ((i / (DEB / 2)) % 2 == 0);
            tick     = (i % 4 == 1);
            tk(1);
        end
        btn_step = 1'b0;
        tick     = 1'b0;
        tk(DEB + 5);
        mid();
        chk("bounce_no_step", 32'(step_seen - base_step), 32'd0);
        chk("bounce_no_ce", 32'(ce_seen - base_ce), 32'd0);
        chk("bounce_cnt", 32'(instr_cnt), 32'(exp_cnt));
        chk("bounce_halt", 32'(state_o), 32'd0);

        // Display path: selection change latency and live refresh
        tk(1);
        sw_sel = 5'd3;
        tk(3);
        mid();
        chk("disp3_valid", 32'(disp_valid), 32'd1);
        chk("disp3_data", 32'(disp_data), 32'h11);
        tk(1);
        sw_sel = 5'd7;
        push("sel_c0_valid", 32'd0); push("sel_c0_data", 32'hFF);
        push("sel_c1_valid", 32'd0); push("sel_c1_data", 32'hFF);
        push("sel_c2_valid", 32'd1); push("sel_c2_data", 32'hA5);
        mid(); pop_check(32'(disp_valid)); pop_check(32'(disp_data));
        tk(1);
        mid(); pop_check(32'(disp_valid)); pop_check(32'(disp_data));
        tk(1);
        mid(); pop_check(32'(disp_valid)); pop_check(32'(disp_data));
        chk("raddr7", 32'(dbg_raddr), 32'd7);
        tk(1);
        rf[7] = 32'h0000_005A;
        mid();
        chk("refresh_old", 32'(disp_data), 32'hA5);
        tk(1);
        mid();
        chk("refresh_new", 32'(disp_data), 32'h5A);

        // Reset in the middle of RUN with a tick present
        tk(1);
        sw_run = 1'b1;
        tk(3);
        mid();
        chk("rerun", 32'(state_o), 32'd1);
        tk(1);
        tick  = 1'b1;
        reset = 1'b0;
        mid();
        chk("rst_run_core_en", 32'(core_en), 32'd0);
        tk(1);
        tick   = 1'b0;
        sw_run = 1'b0;
        exp_cnt = 16'd0;
        mid();
        chk("rst_run_cnt", 32'(instr_cnt), 32'(exp_cnt));
        chk("rst_run_state", 32'(state_o), 32'd0);
        tk(1);
        reset = 1'b1;
        tk(3);

        // Reset in the middle of STEP
        base_ce  = ce_seen;
        btn_step = 1'b1;
        k = 0;
        while (state_o !== 2'd2 && k < 40) begin
            tk(1);
            k++;
        end
        mid();
        chk("step_reached", 32'(state_o), 32'd2);
        tk(1);
        tick     = 1'b1;
        reset    = 1'b0;
        btn_step = 1'b0;
        mid();
        chk("rst_step_core_en", 32'(core_en), 32'd0);
        tk(1);
        tick  = 1'b0;
        reset = 1'b1;
        tk(DEB + 5);
        mid();
        chk("rst_step_halt", 32'(state_o), 32'd0);
        chk("rst_step_no_ce", 32'(ce_seen - base_ce), 32'd0);
        chk("rst_step_cnt", 32'(instr_cnt), 32'd0);

        // Counter wrap
        tk(1);
        sw_run = 1'b1;
        tk(3);
        tick = 1'b1;
        tk(65535);
        mid();
        chk("cnt_ffff", 32'(instr_cnt), 32'h0000_FFFF);
        tk(1);
        tick = 1'b0;
        mid();
        chk("cnt_wrap", 32'(instr_cnt), 32'h0000_0000);
        chk("wrap_run", 32'(state_o), 32'd1);

        if (val_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", val_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
